prbs31_checker: RTL and testbench



---
 rtl/prbs31_checker.sv | 173 +++++++++++++++++
 tb/tb_prbs31_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_checker.sv
// prbs31_checker: receive-side PRBS31 (x^31 + x^28 + 1) checker.
// Self-synchronises to the incoming word stream, declares lock after a run
// of clean words, then counts bit errors and checked words (both saturating).
// Optional feature macro: PRBS31_CHECKER_ERRINJ_EN adds injErrTMR, which
// inverts bit 0 of the received word on any processed cycle.
module prbs31_checker #(
  parameter int WORDWIDTH  = 15,
  parameter int LOCKWORDS  = 4,
  parameter int UNLOCKERRS = 4,
  parameter int CNTWIDTH   = 16
) (
  input  logic                 clkTMR,
  input  logic                 resetTMR,
  input  logic                 disTMR,
  input  logic                 clearTMR,
  input  logic [WORDWIDTH-1:0] dinTMR,
`ifdef PRBS31_CHECKER_ERRINJ_EN
  input  logic                 injErrTMR,
`endif
  output logic                 lockedTMR,
  output logic                 errFlagTMR,
  output logic [CNTWIDTH-1:0]  errCountTMR,
  output logic [CNTWIDTH-1:0]  wordCountTMR
);

  localparam int FILLWORDS = (31 + WORDWIDTH - 1) / WORDWIDTH;
  localparam int FW = $clog2(FILLWORDS + 1);
  localparam int MW = $clog2(LOCKWORDS + 1);
  localparam int RW = $clog2(UNLOCKERRS + 1);
  localparam int PW = $clog2(WORDWIDTH + 1);
  localparam logic [FW-1:0] FILLLAST   = FW'(FILLWORDS - 1);
  localparam logic [MW-1:0] LOCKLAST   = MW'(LOCKWORDS - 1);
  localparam logic [RW-1:0] UNLOCKLAST = RW'(UNLOCKERRS - 1);

  typedef enum logic [1:0] {FILL, VERIFY, LOCKED} state_t;

  state_t               state, stateNext;
  logic [30:0]          hist, histNext, predHist;
  logic [FW-1:0]        fillCnt, fillNext;
  logic [MW-1:0]        matchCnt, matchNext;
  logic [RW-1:0]        errRun, errRunNext;
  logic                 flagNext;
  logic [CNTWIDTH-1:0]  errNext, wordNext;
  logic [WORDWIDTH-1:0] dinEff, expWord, diffBits;
  logic [PW-1:0]        popCnt;

  // Advance the 31-bit history by one word's worth of generator steps.
  function automatic logic [30:0] advance(input logic [30:0] h);
    logic [30:0] r;
    r = h;
    for (int i = 0; i < WORDWIDTH; i++) r = {r[3] ^ r[0], r[30:1]};
    return r;
  endfunction

  // Add with saturation at all-ones; the counter never wraps.
  function automatic logic [CNTWIDTH-1:0] satAdd(input logic [CNTWIDTH-1:0] a,
                                                 input logic [CNTWIDTH-1:0] b);
    logic [CNTWIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNTWIDTH] ? '1 : sum[CNTWIDTH-1:0];
  endfunction

`ifdef PRBS31_CHECKER_ERRINJ_EN
  assign dinEff = dinTMR ^ WORDWIDTH'(injErrTMR);
`else
  assign dinEff = dinTMR;
`endif

  // The newest WORDWIDTH bits of the advanced history are the expected word,
  // with the earliest stream bit landing in bit 0.
  assign predHist = advance(hist);
  assign expWord  = predHist[30 -: WORDWIDTH];
  assign diffBits = dinEff ^ expWord;
  assign popCnt   = PW'($countones(diffBits));

  // Next-state and next-value logic for the FSM, history and counters.
  always_comb begin
    stateNext  = state;
    histNext   = hist;
    fillNext   = fillCnt;
    matchNext  = matchCnt;
    errRunNext = errRun;
    flagNext   = errFlagTMR;
    errNext    = errCountTMR;
    wordNext   = wordCountTMR;
    if (!disTMR) begin
      unique case (state)
        FILL: begin
          flagNext = 1'b0;
          histNext = {dinEff, hist[30:WORDWIDTH]};
          if (fillCnt == FILLLAST) begin
            fillNext = '0;
            // An all-zero history is the generator's lock-up state; keep filling.
            if (histNext != '0) begin
              stateNext = VERIFY;
              matchNext = '0;
            end
          end else begin
            fillNext = fillCnt + 1'b1;
          end
        end
        VERIFY: begin
          flagNext = 1'b0;
          histNext = predHist;
          if (popCnt != '0) begin
            stateNext = FILL;
            fillNext  = '0;
            matchNext = '0;
          end else if (matchCnt == LOCKLAST) begin
            stateNext  = LOCKED;
            matchNext  = '0;
            errRunNext = '0;
          end else begin
            matchNext = matchCnt + 1'b1;
          end
        end
        LOCKED: begin
          // History follows the prediction so a channel error is counted once.
          histNext = predHist;
          errNext  = satAdd(errCountTMR, CNTWIDTH'(popCnt));
          wordNext = satAdd(wordCountTMR, CNTWIDTH'(1));
          flagNext = (popCnt != '0);
          if (popCnt != '0) begin
            if (errRun == UNLOCKLAST) begin
              stateNext  = FILL;
              fillNext   = '0;
              errRunNext = '0;
              flagNext   = 1'b0;
            end else begin
              errRunNext = errRun + 1'b1;
            end
          end else begin
            errRunNext = '0;
          end
        end
        default: begin
          stateNext = FILL;
          fillNext  = '0;
        end
      endcase
    end
    if (clearTMR) begin
      errNext  = '0;
      wordNext = '0;
    end
  end

  // State, history, counters and registered outputs.
  always_ff @(posedge clkTMR) begin
    if (!resetTMR) begin
      state        <= FILL;
      hist         <= '0;
      fillCnt      <= '0;
      matchCnt     <= '0;
      errRun       <= '0;
      lockedTMR    <= 1'b0;
      errFlagTMR   <= 1'b0;
      errCountTMR  <= '0;
      wordCountTMR <= '0;
    end else begin
      state        <= stateNext;
      hist         <= histNext;
      fillCnt      <= fillNext;
      matchCnt     <= matchNext;
      errRun       <= errRunNext;
      lockedTMR    <= (stateNext == LOCKED);
      errFlagTMR   <= flagNext;
      errCountTMR  <= errNext;
      wordCountTMR <= wordNext;
    end
  end

endmodule

// File: tb/tb_prbs31_checker.sv
// tb_prbs31_checker: randomized scoreboard bench for prbs31_checker.
// A bit-stream reference model predicts each cycle's outputs; a monitor on
// the falling edge pops and compares them.
module tb_prbs31_checker;

  localparam int W    = 15;
  localparam int CW   = 10;
  localparam int MAXC = (1 << CW) - 1;
  localparam int FILLN = (31 + W - 1) / W;
`ifdef PRBS31_CHECKER_ERRINJ_EN
  localparam bit INJON = 1'b1;
`else
  localparam bit INJON = 1'b0;
`endif

  logic          clkTMR = 1'b0;
  logic          resetTMR, disTMR, clearTMR, injErrTMR;
  logic [W-1:0]  dinTMR;
  logic          lockedTMR, errFlagTMR;
  logic [CW-1:0] errCountTMR, wordCountTMR;

  prbs31_checker #(.WORDWIDTH(W), .LOCKWORDS(4), .UNLOCKERRS(4), .CNTWIDTH(CW)) dut (
    .clkTMR(clkTMR),
    .resetTMR(resetTMR),
    .disTMR(disTMR),
    .clearTMR(clearTMR),
    .dinTMR(dinTMR),
`ifdef PRBS31_CHECKER_ERRINJ_EN
    .injErrTMR(injErrTMR),
`endif
    .lockedTMR(lockedTMR),
    .errFlagTMR(errFlagTMR),
    .errCountTMR(errCountTMR),
    .wordCountTMR(wordCountTMR)
  );

  always #5 clkTMR = ~clkTMR;

  typedef struct {
    bit l;
    bit f;
    int ec;
    int wc;
  } exp_t;

  exp_t expQ[$];
  int   nAssert = 0;
  int   nFail = 0;

  // Generator: whole stream s[n] = s[n-31] ^ s[n-28], seeded with 31'h1.
  bit   sBits[$];
  int   gPos;

  // Reference model: state as small integers, history as a bit queue.
  int   mState;  // 0 = filling, 1 = verifying, 2 = locked
  int   mFill, mMatch, mRun, mErr, mWord;
  bit   mFlag;
  bit   mHist[$];

  task automatic chk(input string name, input int act, input int req);
    nAssert++;
    if (act != req) begin
      nFail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit getBit(input int n);
    while (sBits.size() <= n)
      sBits.push_back(sBits[sBits.size() - 31] ^ sBits[sBits.size() - 28]);
    return sBits[n];
  endfunction

  task automatic nextWord(output logic [W-1:0] w);
    for (int i = 0; i < W; i++) w[i] = getBit(gPos + i);
    gPos += W;
  endtask

  task automatic modelReset();
    mState = 0; mFill = 0; mMatch = 0; mRun = 0; mErr = 0; mWord = 0; mFlag = 0;
    mHist.delete();
    for (int i = 0; i < 31; i++) mHist.push_back(1'b0);
  endtask

  task automatic modelStep(input logic [W-1:0] d, input bit dis, input bit clr, input bit rstn);
    logic [W-1:0] e;
    int nerr;
    int prev;
    bit anyOne;
    if (!rstn) begin
      modelReset();
      return;
    end
    if (!dis) begin
      prev = mState;
      if (mState == 0) begin
        for (int i = 0; i < W; i++) begin
          mHist.push_back(d[i]);
          void'(mHist.pop_front());
        end
        mFill++;
        if (mFill == FILLN) begin
          mFill = 0;
          anyOne = 0;
          foreach (mHist[i]) anyOne |= mHist[i];
          if (anyOne) begin mState = 1; mMatch = 0; end
        end
        mFlag = 0;
      end else begin
        for (int i = 0; i < W; i++) begin
          e[i] = mHist[0] ^ mHist[3];
          mHist.push_back(e[i]);
          void'(mHist.pop_front());
        end
        nerr = $countones(d ^ e);
        if (prev == 1) begin
          if (nerr != 0) begin mState = 0; mFill = 0; mMatch = 0; end
          else begin
            mMatch++;
            if (mMatch == 4) begin mState = 2; mMatch = 0; mRun = 0; end
          end
          mFlag = 0;
        end else begin
          mErr  = (mErr + nerr > MAXC) ? MAXC : mErr + nerr;
          mWord = (mWord + 1 > MAXC) ? MAXC : mWord + 1;
          if (nerr != 0) begin
            mRun++;
            if (mRun == 4) begin mState = 0; mFill = 0; mRun = 0; end
          end else mRun = 0;
          mFlag = (nerr != 0) && (mState == 2);
        end
      end
    end
    if (clr) begin mErr = 0; mWord = 0; end
  endtask

  // Drive one cycle, advance the model, queue the post-edge expectation.
  task automatic cycle(input logic [W-1:0] d, input bit dis, input bit clr,
                       input bit rstn, input bit inj);
    exp_t e;
    logic [W-1:0] de;
    dinTMR = d; disTMR = dis; clearTMR = clr; resetTMR = rstn; injErrTMR = inj;
    de = d ^ W'(INJON && inj);
    modelStep(de, dis, clr, rstn);
    e.l = (mState == 2); e.f = mFlag; e.ec = mErr; e.wc = mWord;
    @(posedge clkTMR);
    expQ.push_back(e);
    #1;
  endtask

  task automatic cleanWords(input int n);
    logic [W-1:0] w;
    for (int i = 0; i < n; i++) begin
      nextWord(w);
      cycle(w, 0, 0, 1, 0);
    end
  endtask

  task automatic errWord(input logic [W-1:0] mask, input bit clr);
    logic [W-1:0] w;
    nextWord(w);
    cycle(w ^ mask, 0, clr, 1, 0);
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) cycle(W'($urandom), 0, 0, 0, 0);
    gPos = 0;
  endtask

  // Monitor: compare every queued expectation against the DUT outputs.
  always @(negedge clkTMR) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("lockedTMR", int'(lockedTMR), int'(e.l));
      chk("errFlagTMR", int'(errFlagTMR), int'(e.f));
      chk("errCountTMR", int'(errCountTMR), e.ec);
      chk("wordCountTMR", int'(wordCountTMR), e.wc);
    end
  end

  initial begin
    logic [W-1:0] w;
    int processed;
    sBits.delete();
    for (int i = 0; i < 31; i++) sBits.push_back(i == 0);
    gPos = 0;
    modelReset();
    dinTMR = '0; disTMR = 0; clearTMR = 0; resetTMR = 0; injErrTMR = 0;

    // Reset, then lock acquisition on a clean stream.
    doReset(3);
    cleanWords(12);

    // Single-bit error while locked.
    errWord(W'(1 << 5), 0);
    cleanWords(5);

    // Clear, then four fully inverted words drop lock; resume and relock.
    w = '1;
    cleanWords(1);
    cycle(W'(0), 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) errWord(w, 0);
    cleanWords(10);

    // Clear colliding with a 3-bit-error word.
    errWord(W'((1 << 2) | (1 << 7) | (1 << 11)), 1);
    cleanWords(3);

    // All-zero input never locks.
    doReset(1);
    for (int i = 0; i < 100; i++) cycle('0, 0, 0, 1, 0);

    // Stalls in every state with the stream paused in step.
    doReset(1);
    for (int i = 0; i < 12; i++) begin
      cleanWords(1);
      for (int g = 0; g < $urandom_range(1, 3); g++) cycle(W'($urandom), 1, 0, 1, $urandom_range(0, 1));
    end

    // Reset pulse while locked, then relock.
    doReset(1);
    cleanWords(9);

    // Injection pulse while locked.
    nextWord(w);
    cycle(w, 0, 0, 1, 1);
    cleanWords(3);

    // Saturation: never more than three errored words in a row.
    for (int i = 0; i < 1100; i++) begin
      if (i % 4 != 3) errWord(W'($urandom_range(1, (1 << W) - 1)), 0);
      else cleanWords(1);
    end
    cleanWords(2);

    // Random mix of stalls, errors, clears and occasional resets.
    processed = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) doReset(1);
      else if ($urandom_range(0, 4) == 0)
        cycle(W'($urandom), 1, $urandom_range(0, 29) == 0, 1, 0);
      else begin
        nextWord(w);
        if ($urandom_range(0, 7) == 0) w ^= W'($urandom_range(1, (1 << W) - 1));
        cycle(w, 0, $urandom_range(0, 49) == 0, 1, $urandom_range(0, 19) == 0);
        processed++;
      end
    end

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clkTMR);
    #1;
    if (expQ.size() != 0) chk("scoreboardDrain", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
